// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter. Loads a 1..PW bit pattern and shifts it out
// MSB-first (pattern_i[len_i-1] first), one bit per clk, with a repeat count
// and a programmable idle gap between repetitions.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start_i         transfer request, accepted only while ready_o=1
//   pattern_i       bits to send
//   len_i           bits per repetition, legal range 1..PW
//   repeat_n_i      number of repetitions, 0 treated as 1
//   gap_i           idle cycles between repetitions
//   abort_i         synchronous cancel of the current transfer
//   ready_o         1 while idle (decoded from state, not registered)
//   bout_o          serial data, 0 whenever bvalid_o=0
//   bvalid_o        bout_o carries a pattern bit
//   frame_start_o   pulse with the first bit of each repetition
//   done_o          pulse after the last bit of the last repetition
//   err_o           pulse when start_i is rejected for an illegal len_i
module seq_pattern_gen #(
  parameter int unsigned PW = 8,
  parameter int unsigned LW = 4,
  parameter int unsigned CW = 8,
  parameter int unsigned GW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [PW-1:0] pattern_i,
  input  logic [LW-1:0] len_i,
  input  logic [CW-1:0] repeat_n_i,
  input  logic [GW-1:0] gap_i,
  input  logic          abort_i,
  output logic          ready_o,
  output logic          bout_o,
  output logic          bvalid_o,
  output logic          frame_start_o,
  output logic          done_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q;
  logic [PW-1:0] pat_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] idx_q;
  logic [CW-1:0] rep_q;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gcnt_q;
  logic          bout_q;
  logic          bvalid_q;
  logic          frame_start_q;
  logic          done_q;
  logic          err_q;

  // Select one bit of a pattern; an out-of-range index yields 0.
  function automatic logic pick_bit(input logic [PW-1:0] v, input logic [LW-1:0] s);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (LW'(i) == s) b = v[i];
    end
    return b;
  endfunction

  logic          len_ok;
  logic          last_bit;
  logic [LW-1:0] idx_inc;
  logic          first_new;
  logic          first_rep;
  logic          next_bit;

  // Next-bit selection: first bit of a new request, first bit of a repeat,
  // and the bit following the one currently on bout.
  always_comb begin
    len_ok    = (len_i != '0) && (32'(len_i) <= PW);
    last_bit  = (idx_q == (len_q - LW'(1)));
    idx_inc   = idx_q + LW'(1);
    first_new = pick_bit(pattern_i, len_i - LW'(1));
    first_rep = pick_bit(pat_q, len_q - LW'(1));
    next_bit  = pick_bit(pat_q, len_q - LW'(1) - idx_inc);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pat_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      rep_q         <= '0;
      gap_q         <= '0;
      gcnt_q        <= '0;
      bout_q        <= 1'b0;
      bvalid_q      <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      if (abort_i && (state_q != S_IDLE)) begin
        // Cancel: straight back to idle, no done pulse.
        state_q  <= S_IDLE;
        idx_q    <= '0;
        rep_q    <= '0;
        gcnt_q   <= '0;
        bout_q   <= 1'b0;
        bvalid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // abort_i in idle suppresses a simultaneous start_i.
            if (start_i && !abort_i) begin
              if (len_ok) begin
                state_q       <= S_SHIFT;
                pat_q         <= pattern_i;
                len_q         <= len_i;
                rep_q         <= (repeat_n_i == '0) ? CW'(1) : repeat_n_i;
                gap_q         <= gap_i;
                idx_q         <= '0;
                gcnt_q        <= '0;
                bout_q        <= first_new;
                bvalid_q      <= 1'b1;
                frame_start_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_SHIFT: begin
            if (last_bit) begin
              idx_q <= '0;
              if (rep_q > CW'(1)) begin
                rep_q <= rep_q - CW'(1);
                if (gap_q != '0) begin
                  state_q  <= S_GAP;
                  gcnt_q   <= gap_q - GW'(1);
                  bout_q   <= 1'b0;
                  bvalid_q <= 1'b0;
                end else begin
                  bout_q        <= first_rep;
                  frame_start_q <= 1'b1;
                end
              end else begin
                state_q  <= S_DONE;
                rep_q    <= '0;
                bout_q   <= 1'b0;
                bvalid_q <= 1'b0;
                done_q   <= 1'b1;
              end
            end else begin
              idx_q  <= idx_inc;
              bout_q <= next_bit;
            end
          end
          S_GAP: begin
            // gcnt_q was loaded with gap-1, so the gap spans exactly gap_q cycles.
            if (gcnt_q == '0) begin
              state_q       <= S_SHIFT;
              idx_q         <= '0;
              bout_q        <= first_rep;
              bvalid_q      <= 1'b1;
              frame_start_q <= 1'b1;
            end else begin
              gcnt_q <= gcnt_q - GW'(1);
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ready_o       = (state_q == S_IDLE);
  assign bout_o        = bout_q;
  assign bvalid_o      = bvalid_q;
  assign frame_start_o = frame_start_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed testbench for seq_pattern_gen. Inputs change on the falling edge,
// outputs are sampled on the falling edge, so each sample shows the state
// left by the preceding rising edge.
module tb_seq_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [7:0] repeat_n;
  logic [3:0] gap;
  logic       abort;
  logic       ready;
  logic       bout;
  logic       bvalid;
  logic       frame_start;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  seq_pattern_gen #(.PW(8), .LW(4), .CW(8), .GW(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .pattern_i     (pattern),
    .len_i         (len),
    .repeat_n_i    (repeat_n),
    .gap_i         (gap),
    .abort_i       (abort),
    .ready_o       (ready),
    .bout_o        (bout),
    .bvalid_o      (bvalid),
    .frame_start_o (frame_start),
    .done_o        (done),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: hold start for one rising edge, return in the first
  // output cycle after that edge.
  task automatic kick(input logic [7:0] p, input logic [3:0] l,
                      input logic [7:0] r, input logic [3:0] g);
    pattern  = p;
    len      = l;
    repeat_n = r;
    gap      = g;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready, bvalid, bout, frame_start, done, err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_async got %b exp 100000", {ready, bvalid, bout, frame_start, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready, bvalid, bout, frame_start, done, err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_release got %b exp 100000", {ready, bvalid, bout, frame_start, done, err});
    end
  endtask

  // T1: 1010 once, done in cycle 5, ready in cycle 6.
  task automatic test_single();
    logic [4:0] ebv, ebo, efs, edn;
    ebv = 5'b11110; ebo = 5'b10100; efs = 5'b10000; edn = 5'b00001;
    kick(8'h0A, 4'd4, 8'd1, 4'd0);
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if ({ready, bvalid, bout, frame_start, done} !== {1'b0, ebv[4], ebo[4], efs[4], edn[4]}) begin
        errors++;
        $display("FAIL single cyc%0d got %b exp %b", i, {ready, bvalid, bout, frame_start, done},
                 {1'b0, ebv[4], ebo[4], efs[4], edn[4]});
      end
      ebv = ebv << 1; ebo = ebo << 1; efs = efs << 1; edn = edn << 1;
      @(negedge clk);
    end
    checks++;
    if ({ready, bvalid, done} !== 3'b100) begin
      errors++;
      $display("FAIL single_ready got %b exp 100", {ready, bvalid, done});
    end
  endtask

  // T2: three back-to-back repetitions, frame_start at 1,5,9; 1010 seen 5 times.
  task automatic test_back_to_back();
    logic [12:0] ebv, ebo, efs, edn;
    logic [3:0]  win;
    int          hits;
    ebv = 13'b1111111111110; ebo = 13'b1010101010100;
    efs = 13'b1000100010000; edn = 13'b0000000000001;
    win = 4'b0000; hits = 0;
    kick(8'h0A, 4'd4, 8'd3, 4'd0);
    for (int i = 1; i <= 13; i++) begin
      checks++;
      if ({ready, bvalid, bout, frame_start, done} !== {1'b0, ebv[12], ebo[12], efs[12], edn[12]}) begin
        errors++;
        $display("FAIL b2b cyc%0d got %b exp %b", i, {ready, bvalid, bout, frame_start, done},
                 {1'b0, ebv[12], ebo[12], efs[12], edn[12]});
      end
      if (bvalid) begin
        win = {win[2:0], bout};
        if (win == 4'b1010) hits++;
      end
      ebv = ebv << 1; ebo = ebo << 1; efs = efs << 1; edn = edn << 1;
      @(negedge clk);
    end
    checks++;
    if (hits !== 5) begin
      errors++;
      $display("FAIL b2b_detect got %0d exp 5", hits);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready got %b exp 1", ready);
    end
  endtask

  // T3: two repetitions separated by two idle cycles, done in cycle 11.
  task automatic test_gap();
    logic [10:0] ebv, ebo, efs, edn;
    ebv = 11'b11110011110; ebo = 11'b10100010100;
    efs = 11'b10000010000; edn = 11'b00000000001;
    kick(8'h0A, 4'd4, 8'd2, 4'd2);
    for (int i = 1; i <= 11; i++) begin
      checks++;
      if ({ready, bvalid, bout, frame_start, done} !== {1'b0, ebv[10], ebo[10], efs[10], edn[10]}) begin
        errors++;
        $display("FAIL gap cyc%0d got %b exp %b", i, {ready, bvalid, bout, frame_start, done},
                 {1'b0, ebv[10], ebo[10], efs[10], edn[10]});
      end
      ebv = ebv << 1; ebo = ebo << 1; efs = efs << 1; edn = edn << 1;
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL gap_ready got %b exp 1", ready);
    end
  endtask

  // T4: len=0 and len=9 are rejected with an err pulse.
  task automatic test_illegal_len();
    logic [3:0] bad [2];
    bad[0] = 4'd0; bad[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      kick(8'hFF, bad[k], 8'd1, 4'd0);
      checks++;
      if ({ready, bvalid, err} !== 3'b101) begin
        errors++;
        $display("FAIL illegal_len%0d got %b exp 101", bad[k], {ready, bvalid, err});
      end
      @(negedge clk);
      checks++;
      if ({ready, bvalid, err} !== 3'b100) begin
        errors++;
        $display("FAIL illegal_len%0d_after got %b exp 100", bad[k], {ready, bvalid, err});
      end
    end
  endtask

  // len=1 with a one-cycle gap, then repeat_n=0 behaving as a single repetition.
  task automatic test_boundary();
    logic [3:0] ebv, ebo, efs, edn;
    logic [2:0] rbv, rbo, rdn;
    ebv = 4'b1010; ebo = 4'b1010; efs = 4'b1010; edn = 4'b0001;
    kick(8'h01, 4'd1, 8'd2, 4'd1);
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({ready, bvalid, bout, frame_start, done} !== {1'b0, ebv[3], ebo[3], efs[3], edn[3]}) begin
        errors++;
        $display("FAIL len1 cyc%0d got %b exp %b", i, {ready, bvalid, bout, frame_start, done},
                 {1'b0, ebv[3], ebo[3], efs[3], edn[3]});
      end
      ebv = ebv << 1; ebo = ebo << 1; efs = efs << 1; edn = edn << 1;
      @(negedge clk);
    end
    rbv = 3'b110; rbo = 3'b100; rdn = 3'b001;
    kick(8'h02, 4'd2, 8'd0, 4'd3);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if ({ready, bvalid, bout, done} !== {1'b0, rbv[2], rbo[2], rdn[2]}) begin
        errors++;
        $display("FAIL rep0 cyc%0d got %b exp %b", i, {ready, bvalid, bout, done},
                 {1'b0, rbv[2], rbo[2], rdn[2]});
      end
      rbv = rbv << 1; rbo = rbo << 1; rdn = rdn << 1;
      @(negedge clk);
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL rep0_ready got %b exp 1", ready);
    end
  endtask

  // T5: 8-bit A5 ignoring a mid-transfer start, then an abort in cycle 2.
  task automatic test_abort();
    logic [7:0] ebo;
    ebo = 8'hA5;
    kick(8'hA5, 4'd8, 8'd1, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if ({ready, bvalid, bout} !== {2'b01, ebo[7]}) begin
        errors++;
        $display("FAIL a5 cyc%0d got %b exp %b", i, {ready, bvalid, bout}, {2'b01, ebo[7]});
      end
      ebo = ebo << 1;
      // Foreign request during cycle 3 must have no effect.
      if (i == 3) begin
        pattern = 8'h0F; len = 4'd2; repeat_n = 8'd5; gap = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if ({ready, bvalid, done} !== 3'b001) begin
      errors++;
      $display("FAIL a5_done got %b exp 001", {ready, bvalid, done});
    end
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL a5_ready got %b exp 1", ready);
    end
    kick(8'hA5, 4'd8, 8'd1, 4'd0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ready, bvalid, bout, done} !== 4'b1000) begin
        errors++;
        $display("FAIL abort_cyc%0d got %b exp 1000", i, {ready, bvalid, bout, done});
      end
      @(negedge clk);
    end
    // abort and start together in idle: start dropped.
    pattern = 8'h0A; len = 4'd4; repeat_n = 8'd1; gap = 4'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({ready, bvalid, frame_start, err} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_idle got %b exp 1000", {ready, bvalid, frame_start, err});
    end
  endtask

  // T6: asynchronous reset mid-shift.
  task automatic test_async_reset();
    kick(8'hA5, 4'd8, 8'd1, 4'd0);
    @(negedge clk);
    checks++;
    if ({ready, bvalid, bout} !== 3'b010) begin
      errors++;
      $display("FAIL ares_pre got %b exp 010", {ready, bvalid, bout});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, bvalid, bout, done} !== 4'b1000) begin
      errors++;
      $display("FAIL ares_async got %b exp 1000", {ready, bvalid, bout, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({ready, bvalid, done} !== 3'b100) begin
        errors++;
        $display("FAIL ares_post%0d got %b exp 100", i, {ready, bvalid, done});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; repeat_n = '0; gap = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_illegal_len();
    test_boundary();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
